sd_data_fifo: RTL

Single-clock 32-bit synchronous FIFO between the host DMA side and the SD data physical layer. In write operations (host to card) it buffers words from the DMA and feeds the parallel-to-serial converter. In read operations (card to host) it buffers words from the serial-to-parallel converter for the DMA. It also generates the `iFIFO_ok` qualifier that the data control FSM waits on in CHECK_FIFO.

---
 rtl/sd_data_fifo.sv | 73 +++++++
 1 files changed

// File: rtl/sd_data_fifo.sv
// sd_data_fifo: 32-bit single-clock FIFO between host DMA and SD data PHY, with a direction-qualified level flag
module sd_data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int THRESHOLD  = 4
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iClear,
  input  logic                  iWriteRead,
  input  logic                  iWrite_enable,
  input  logic [DATA_WIDTH-1:0] iData_in,
  input  logic                  iRead_enable,
  output logic [DATA_WIDTH-1:0] oData_out,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFIFO_ok,
  output logic                  oOverflow,
  output logic                  oUnderflow
);
  localparam logic [ADDR_WIDTH:0] FullCount   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ThreshCount = (ADDR_WIDTH+1)'(THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wPtr;
  logic [ADDR_WIDTH-1:0] rPtr;
  logic [ADDR_WIDTH:0]   count;
  logic                  popOk;
  logic                  pushOk;

  // A push into a full FIFO is still legal when a pop frees a slot in the same cycle; no bypass when empty
  assign popOk  = iRead_enable && (count != '0);
  assign pushOk = iWrite_enable && ((count != FullCount) || popOk);

  assign oCount   = count;
  assign oFull    = count == FullCount;
  assign oEmpty   = count == '0;
  assign oFIFO_ok = iWriteRead ? (count >= ThreshCount) : ((FullCount - count) >= ThreshCount);

  // Storage write; contents are deliberately left untouched by reset and clear
  always_ff @(posedge iClock) begin
    if (iReset && !iClear && pushOk) mem[wPtr] <= iData_in;
  end

  // Pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      wPtr       <= '0;
      rPtr       <= '0;
      count      <= '0;
      oData_out  <= '0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else if (iClear) begin
      wPtr       <= '0;
      rPtr       <= '0;
      count      <= '0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (pushOk) wPtr <= wPtr + 1'b1;
      if (popOk) begin
        oData_out <= mem[rPtr];
        rPtr      <= rPtr + 1'b1;
      end
      if (pushOk != popOk) count <= pushOk ? count + 1'b1 : count - 1'b1;
      if (iWrite_enable && !pushOk) oOverflow <= 1'b1;
      if (iRead_enable && !popOk) oUnderflow <= 1'b1;
    end
  end
endmodule
